// File: rtl/crt_recombine.sv
// Garner CRT recombination: m = mq + q*(((mp - mq) mod p) * qinv mod p), bit-serial.
// Optional input screening is compiled in with `define CRT_INPUT_CHECK_EN.
module crt_recombine #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     p,
  input  logic [WIDTH-1:0]     q,
  input  logic [WIDTH-1:0]     qinv,
  input  logic [WIDTH-1:0]     mp,
  input  logic [WIDTH-1:0]     mq,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [2*WIDTH-1:0]   m
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, SUB, MUL, COMB, DONE} state_t;

  state_t state, nxt;

  logic [WIDTH-1:0]   p_r, q_r, qinv_r, mp_r, mq_r, d_r, acc, mr;
  logic [2*WIDTH-1:0] prod, qsh;
  logic [CW-1:0]      cnt;
  logic               bad_in, bad_r, accept, last;
  logic [WIDTH:0]     dw;
  logic [WIDTH+1:0]   pe, dbl, dbl_r, sum, sum_r;

`ifdef CRT_INPUT_CHECK_EN
  assign bad_in = (p == '0) | ~p[0] | (mp >= p) | (qinv >= p) | (mq >= q) |
                  ({1'b0, q} >= {p, 1'b0});
`else
  assign bad_in = 1'b0;
`endif

  // done is registered out of DONE, so busy covers the done cycle as well
  assign busy   = (state != IDLE) | done;
  assign accept = (state == IDLE) & ~done & start;
  assign last   = (cnt == CW'(WIDTH-1));

  // d = (mp - mq) mod p, with mq first folded below p (mq < 2p)
  assign mr = (mq_r >= p_r) ? mq_r - p_r : mq_r;
  assign dw = (mp_r >= mr) ? {1'b0, mp_r} - {1'b0, mr}
                           : {1'b0, mp_r} + {1'b0, p_r} - {1'b0, mr};

  // One Horner step of d*qinv mod p, MSB of qinv first
  assign pe    = {2'b00, p_r};
  assign dbl   = {1'b0, acc, 1'b0};
  assign dbl_r = (dbl >= pe) ? dbl - pe : dbl;
  assign sum   = dbl_r + (qinv_r[WIDTH-1] ? {2'b00, d_r} : '0);
  assign sum_r = (sum >= pe) ? sum - pe : sum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = SUB;
      SUB:     nxt = bad_r ? DONE : MUL;
      MUL:     if (last) nxt = COMB;
      COMB:    if (last) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_r <= '0; q_r <= '0; qinv_r <= '0; mp_r <= '0; mq_r <= '0;
      d_r <= '0; acc <= '0; prod <= '0; qsh <= '0; cnt <= '0;
      bad_r <= 1'b0; done <= 1'b0; err <= 1'b0; m <= '0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: if (accept) begin
          p_r    <= p;
          q_r    <= q;
          qinv_r <= qinv;
          mp_r   <= mp;
          mq_r   <= mq;
          bad_r  <= bad_in;
          m      <= '0;
          err    <= 1'b0;
        end
        SUB: begin
          d_r <= dw[WIDTH-1:0];
          acc <= '0;
          cnt <= '0;
        end
        MUL: begin
          acc    <= sum_r[WIDTH-1:0];
          qinv_r <= qinv_r << 1;
          cnt    <= last ? '0 : cnt + 1'b1;
          if (last) begin
            prod <= {{WIDTH{1'b0}}, mq_r};
            qsh  <= {{WIDTH{1'b0}}, q_r};
          end
        end
        COMB: begin
          // LSB-first shift-add of q*h on top of the mq seed
          if (acc[0]) prod <= prod + qsh;
          qsh <= qsh << 1;
          acc <= acc >> 1;
          cnt <= last ? '0 : cnt + 1'b1;
        end
        DONE: begin
          m   <= bad_r ? '0 : prod;
          err <= bad_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crt_recombine.sv
// Directed-vector and model-based bench for crt_recombine (WIDTH=32).
module tb_crt_recombine;

  logic        clk, reset_n, start;
  logic [31:0] p, q, qinv, mp, mq;
  logic        busy, done, err;
  logic [63:0] m;

  int checks = 0;
  int errors = 0;

  crt_recombine #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .p(p), .q(q), .qinv(qinv), .mp(mp), .mq(mq),
    .busy(busy), .done(done), .err(err), .m(m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] p, q, qinv, mp, mq;
    logic [63:0] m;
  } vec_t;

  vec_t tv[8];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, exp, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ip, iq, iqinv, imp, imq);
    p = ip; q = iq; qinv = iqinv; mp = imp; mq = imq;
  endtask

  // Counts edges after the current one until done is seen; -1 on timeout
  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 300) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
    if (!done) lat = -1;
  endtask

  task automatic run(input logic [31:0] ip, iq, iqinv, imp, imq,
                     output logic [63:0] mo, output logic eo, output int lat);
    drive(ip, iq, iqinv, imp, imq);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    mo = m;
    eo = err;
  endtask

  function automatic logic [63:0] mulmod(input logic [63:0] a, b, n);
    return (a * b) % n;
  endfunction

  function automatic logic [31:0] modinv(input logic [63:0] a, input logic [63:0] n);
    logic [63:0] r, base, e;
    r = 1; base = a % n; e = n - 2;
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = mulmod(r, base, n);
      base = mulmod(base, base, n);
    end
    return r[31:0];
  endfunction

  function automatic logic [63:0] model(input logic [63:0] mp_, mq_, p_, q_, qinv_);
    logic [63:0] d, h;
    d = (mp_ + p_ - (mq_ % p_)) % p_;
    h = (d * qinv_) % p_;
    return mq_ + q_ * h;
  endfunction

  logic [63:0] mo;
  logic        eo;
  int          lat, ndone;

  initial begin
    tv[0] = '{32'd61, 32'd53, 32'd38, 32'd4,  32'd12, 64'd65};
    tv[1] = '{32'd53, 32'd61, 32'd20, 32'd5,  32'd58, 64'd58};
    tv[2] = '{32'd53, 32'd61, 32'd20, 32'd12, 32'd4,  64'd65};
    tv[3] = '{32'd61, 32'd53, 32'd38, 32'd0,  32'd0,  64'd0};
    tv[4] = '{32'd61, 32'd53, 32'd38, 32'd60, 32'd52, 64'd3232};
    tv[5] = '{32'd11, 32'd13, 32'd6,  32'd3,  32'd7,  64'd124};
    tv[6] = '{32'd11, 32'd13, 32'd6,  32'd1,  32'd12, 64'd12};
    tv[7] = '{32'd4294967279, 32'd4294967291, 32'd357913940, 32'd0, 32'd4294967290,
              64'h15555553_9555555B};

    reset_n = 1'b0; start = 1'b0;
    drive('0, '0, '0, '0, '0);
    #12;
    chk("reset_m", m, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_err", {63'd0, err}, 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run(tv[i].p, tv[i].q, tv[i].qinv, tv[i].mp, tv[i].mq, mo, eo, lat);
      chk($sformatf("vec%0d_m", i), mo, tv[i].m);
      chk($sformatf("vec%0d_err", i), {63'd0, eo}, 64'd0);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'd66);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_pulse", i), {62'd0, done, busy}, 64'd0);
    end

    // start during busy is ignored; m cleared on accept
    drive(32'd61, 32'd53, 32'd38, 32'd60, 32'd52);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("accept_busy", {63'd0, busy}, 64'd1);
    chk("accept_mclr", m, 64'd0);
    repeat (10) begin @(posedge clk); #1; end
    drive(32'd61, 32'd53, 32'd38, 32'd4, 32'd12);
    start = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b0;
    ndone = 0; lat = 13; mo = '0;
    repeat (120) begin
      @(posedge clk); #1;
      lat++;
      if (done) begin ndone++; if (ndone == 1) begin chk("busy_start_lat", 64'(lat), 64'd66); mo = m; end end
    end
    chk("busy_start_ndone", 64'(ndone), 64'd1);
    chk("busy_start_m", mo, 64'd3232);

    // back-to-back: held start is refused in the done cycle, taken on the next
    run(32'd61, 32'd53, 32'd38, 32'd4, 32'd12, mo, eo, lat);
    chk("b2b_first_m", mo, 64'd65);
    drive(32'd11, 32'd13, 32'd6, 32'd3, 32'd7);
    start = 1'b1;
    @(posedge clk); #1;
    chk("b2b_refused", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_accepted", {63'd0, busy}, 64'd1);
    wait_done(lat);
    chk("b2b_lat", 64'(lat), 64'd66);
    chk("b2b_m", m, 64'd124);

    // reset during MUL
    drive(32'd61, 32'd53, 32'd38, 32'd60, 32'd52);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_m", m, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run(32'd61, 32'd53, 32'd38, 32'd4, 32'd12, mo, eo, lat);
    chk("postrst_m", mo, 64'd65);
    chk("postrst_lat", 64'(lat), 64'd66);
    @(posedge clk); #1;

    // mp == p violates the preconditions
    run(32'd61, 32'd53, 32'd38, 32'd61, 32'd12, mo, eo, lat);
`ifdef CRT_INPUT_CHECK_EN
    chk("chk_lat", 64'(lat), 64'd2);
    chk("chk_err", {63'd0, eo}, 64'd1);
    chk("chk_m", mo, 64'd0);
`else
    chk("chk_lat", 64'(lat), 64'd66);
    chk("chk_err", {63'd0, eo}, 64'd0);
`endif
    @(posedge clk); #1;

    // model-based regression over large prime pairs
    for (int i = 0; i < 30; i++) begin
      logic [31:0] rp, rq, rqi, rmp, rmq;
      case (i % 3)
        0:       begin rp = 32'd4294967279; rq = 32'd4294967291; end
        1:       begin rp = 32'd4294967291; rq = 32'd4294967279; end
        default: begin rp = 32'd2147483647; rq = 32'd4294967291; end
      endcase
      rqi = modinv({32'd0, rq}, {32'd0, rp});
      rmp = $urandom % rp;
      rmq = $urandom % rq;
      run(rp, rq, rqi, rmp, rmq, mo, eo, lat);
      chk($sformatf("rnd%0d_m", i), mo, model({32'd0, rmp}, {32'd0, rmq}, {32'd0, rp}, {32'd0, rq}, {32'd0, rqi}));
      chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'd66);
      chk($sformatf("rnd%0d_err", i), {63'd0, eo}, 64'd0);
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
